// File: rtl/conv_result_requant.sv
// Requantizes the convolution core's accumulator stream to OUT_WIDTH bits and buffers it in a small FIFO.
// Build option: define CONV_REQUANT_ROUND_EN for round-half-up; otherwise results are truncated.
module conv_result_requant #(
  parameter  int DATA_WIDTH        = 8,
  parameter  int MAX_KERNEL_LENGTH = 8,
  parameter  int OUT_WIDTH         = 8,
  parameter  int FIFO_DEPTH        = 4,
  localparam int IN_WIDTH          = 2*DATA_WIDTH + $clog2(MAX_KERNEL_LENGTH),
  localparam int SHIFT_W           = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_vld,
  input  logic                 in_last,
  output logic                 in_rdy,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_vld,
  output logic                 out_last,
  input  logic                 out_rdy,
  output logic [15:0]          sat_count,
  output logic                 frame_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = OUT_WIDTH + 1;
  localparam logic [SHIFT_W-1:0] S_MAX = SHIFT_W'(IN_WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for the first beat of a frame; cfg_shift is used and latched
  // FRAME | inside a frame; latched shift_q is used until in_last
  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t state_q, state_d;
  logic   first_beat;

  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [15:0]          sat_count_q, sat_count_d;
  logic                 frame_done_q, frame_done_d;

  logic                 stage_vld_q, stage_vld_d;
  logic [OUT_WIDTH-1:0] stage_data_q, stage_data_d;
  logic                 stage_last_q, stage_last_d;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 in_acc;
  logic                 fifo_wr;
  logic                 fifo_rd;
  logic [CW-1:0]        occupancy;
  logic [EW-1:0]        rd_entry;

  logic [SHIFT_W-1:0]   shift_eff;
  logic [SHIFT_W-1:0]   s;
  logic [IN_WIDTH:0]    sum;
  logic [IN_WIDTH:0]    r;
  logic                 sat;
  logic [OUT_WIDTH-1:0] q_val;
  logic [15:0]          sat_base;
`ifdef CONV_REQUANT_ROUND_EN
  logic [IN_WIDTH:0]    rnd;
`endif

  // Handshake: in_rdy depends only on registered occupancy, never on out_rdy.
  assign occupancy = count_q + CW'(stage_vld_q);
  assign in_rdy    = occupancy < CW'(FIFO_DEPTH);
  assign in_acc    = in_vld && in_rdy;
  assign out_vld   = (count_q != '0);
  assign fifo_wr   = stage_vld_q;
  assign fifo_rd   = out_vld && out_rdy;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (in_acc) begin
      case (state_q)
        IDLE:    if (!in_last) state_d = FRAME;
        FRAME:   if (in_last)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    first_beat = (state_q == IDLE);
  end

  assign shift_eff = first_beat ? cfg_shift : shift_q;

  // Requantize: clamp shift, optional rounding add, shift, unsigned saturate.
  always_comb begin
    s = (shift_eff > S_MAX) ? S_MAX : shift_eff;
`ifdef CONV_REQUANT_ROUND_EN
    rnd = '0;
    if (s != '0) rnd = {{IN_WIDTH{1'b0}}, 1'b1} << (s - SHIFT_W'(1));
    sum = {1'b0, in_data} + rnd;
`else
    sum = {1'b0, in_data};
`endif
    r     = sum >> s;
    sat   = |r[IN_WIDTH:OUT_WIDTH];
    q_val = sat ? {OUT_WIDTH{1'b1}} : r[OUT_WIDTH-1:0];
  end

  always_comb begin
    shift_d      = shift_q;
    sat_base     = first_beat ? 16'd0 : sat_count_q;
    sat_count_d  = sat_count_q;
    stage_vld_d  = in_acc;
    stage_data_d = stage_data_q;
    stage_last_d = stage_last_q;
    if (in_acc) begin
      if (first_beat) shift_d = cfg_shift;
      sat_count_d  = sat_base;
      if (sat && (sat_base != 16'hFFFF)) sat_count_d = sat_base + 16'd1;
      stage_data_d = q_val;
      stage_last_d = in_last;
    end
    frame_done_d = fifo_rd && out_last;
  end

  // FIFO bookkeeping; the stage never writes into a full FIFO because in_rdy counts it.
  always_comb begin
    mem_d = mem_q;
    if (fifo_wr) mem_d[wr_ptr_q] = {stage_last_q, stage_data_q};
    wr_ptr_d = wr_ptr_q + AW'(fifo_wr);
    rd_ptr_d = rd_ptr_q + AW'(fifo_rd);
    count_d  = count_q + CW'(fifo_wr) - CW'(fifo_rd);
  end

  assign rd_entry  = mem_q[rd_ptr_q];
  assign out_data  = out_vld ? rd_entry[OUT_WIDTH-1:0] : '0;
  assign out_last  = out_vld & rd_entry[OUT_WIDTH];
  assign sat_count = sat_count_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      sat_count_q  <= '0;
      frame_done_q <= 1'b0;
      stage_vld_q  <= 1'b0;
      stage_data_q <= '0;
      stage_last_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      shift_q      <= shift_d;
      sat_count_q  <= sat_count_d;
      frame_done_q <= frame_done_d;
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
      stage_last_q <= stage_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage is not reset; stale entries are masked by out_vld.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_conv_result_requant.sv
// Directed bench for conv_result_requant: single-beat vector table plus multi-beat sequences.
module tb_conv_result_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cfg_shift;
  logic [18:0] in_data;
  logic        in_vld;
  logic        in_last;
  logic        in_rdy;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_last;
  logic        out_rdy;
  logic [15:0] sat_count;
  logic        frame_done;

  int n_vec  = 0;
  int n_fail = 0;

  logic [8:0] outq [$];
  int         fd_cnt = 0;

  always #5 clk = ~clk;

  conv_result_requant dut (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .in_data(in_data),
    .in_vld(in_vld), .in_last(in_last), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_last(out_last),
    .out_rdy(out_rdy), .sat_count(sat_count), .frame_done(frame_done)
  );

  // Inputs only change just after posedge, so a negedge view predicts the next edge's handshake.
  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) outq.push_back({out_last, out_data});
    if (frame_done) fd_cnt++;
  end

  typedef struct {
    logic [4:0]  shift;
    logic [18:0] data;
    logic [7:0]  exp_rnd;
    logic        sat_rnd;
    logic [7:0]  exp_trn;
    logic        sat_trn;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_vld = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic send_beat(input logic [4:0] sh, input logic [18:0] d, input logic last);
    cfg_shift = sh; in_data = d; in_last = last; in_vld = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic check_q(input string name, input int idx, input logic [8:0] exp);
    if (idx < outq.size()) check(name, 32'(outq[idx]), 32'(exp));
    else check({name, "_missing"}, 32'(outq.size()), 32'(idx + 1));
  endtask

  initial begin
    logic [7:0] exp_d;
    logic       exp_s;
    logic [7:0] held;
    int         acc;
    int         guard;

    vecs[0]  = '{5'd4,  19'd44,     8'd3,   1'b0, 8'd2,   1'b0};
    vecs[1]  = '{5'd4,  19'd291,    8'd18,  1'b0, 8'd18,  1'b0};
    vecs[2]  = '{5'd1,  19'd10,     8'd5,   1'b0, 8'd5,   1'b0};
    vecs[3]  = '{5'd0,  19'd255,    8'd255, 1'b0, 8'd255, 1'b0};
    vecs[4]  = '{5'd0,  19'd256,    8'd255, 1'b1, 8'd255, 1'b1};
    vecs[5]  = '{5'd8,  19'd65535,  8'd255, 1'b1, 8'd255, 1'b0};
    vecs[6]  = '{5'd31, 19'd524287, 8'd2,   1'b0, 8'd1,   1'b0};
    vecs[7]  = '{5'd2,  19'd6,      8'd2,   1'b0, 8'd1,   1'b0};
    vecs[8]  = '{5'd18, 19'd262144, 8'd1,   1'b0, 8'd1,   1'b0};
    vecs[9]  = '{5'd3,  19'd2047,   8'd255, 1'b1, 8'd255, 1'b0};
    vecs[10] = '{5'd0,  19'd0,      8'd0,   1'b0, 8'd0,   1'b0};
    vecs[11] = '{5'd5,  19'd8175,   8'd255, 1'b0, 8'd255, 1'b0};

    rst = 1'b1; cfg_shift = '0; out_rdy = 1'b0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Single-beat frames: each starts in IDLE and uses cfg_shift directly.
    for (int i = 0; i < 12; i++) begin
`ifdef CONV_REQUANT_ROUND_EN
      exp_d = vecs[i].exp_rnd; exp_s = vecs[i].sat_rnd;
`else
      exp_d = vecs[i].exp_trn; exp_s = vecs[i].sat_trn;
`endif
      out_rdy = 1'b0;
      check($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'd1);
      send_beat(vecs[i].shift, vecs[i].data, 1'b1);
      check($sformatf("v%0d_lat_no_vld", i), 32'(out_vld), 32'd0);
      tick();
      check($sformatf("v%0d_out_vld", i), 32'(out_vld), 32'd1);
      check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(exp_d));
      check($sformatf("v%0d_out_last", i), 32'(out_last), 32'd1);
      check($sformatf("v%0d_sat_count", i), 32'(sat_count), 32'(exp_s));
      out_rdy = 1'b1;
      tick();
      check($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'd1);
      check($sformatf("v%0d_drained", i), 32'(out_vld), 32'd0);
      out_rdy = 1'b0;
      tick();
      check($sformatf("v%0d_fd_pulse", i), 32'(frame_done), 32'd0);
    end

    // Saturation frame 300, 255, 256(last) at shift 0.
    outq.delete(); fd_cnt = 0; out_rdy = 1'b1;
    send_beat(5'd0, 19'd300, 1'b0);
    send_beat(5'd0, 19'd255, 1'b0);
    send_beat(5'd0, 19'd256, 1'b1);
    repeat (5) tick();
    check("sat_nbeats", 32'(outq.size()), 32'd3);
    check_q("sat_b0", 0, {1'b0, 8'd255});
    check_q("sat_b1", 1, {1'b0, 8'd255});
    check_q("sat_b2", 2, {1'b1, 8'd255});
    check("sat_count", 32'(sat_count), 32'd2);
    check("sat_fd_count", 32'(fd_cnt), 32'd1);

    // Backpressure: 8-beat frame with the output stalled.
    outq.delete(); fd_cnt = 0; out_rdy = 1'b0; acc = 0;
    cfg_shift = 5'd0;
    for (int c = 0; c < 10; c++) begin
      in_vld = 1'b1; in_data = 19'(acc + 1); in_last = (acc == 7);
      if (in_rdy) acc++;
      tick();
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_in_rdy_low", 32'(in_rdy), 32'd0);
    held = out_data;
    check("bp_head", 32'(held), 32'd1);
    tick();
    check("bp_hold", 32'(out_data), 32'(held));
    out_rdy = 1'b1; guard = 0;
    while (acc < 8 && guard < 40) begin
      in_vld = 1'b1; in_data = 19'(acc + 1); in_last = (acc == 7);
      if (in_rdy) acc++;
      tick();
      guard++;
    end
    idle_inputs();
    check("bp_all_accepted", 32'(acc), 32'd8);
    repeat (8) tick();
    check("bp_nbeats", 32'(outq.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      check_q($sformatf("bp_b%0d", k), k, {(k == 7), 8'(k + 1)});
    check("bp_fd_count", 32'(fd_cnt), 32'd1);

    // Shift latch: cfg_shift change mid-frame is ignored.
    outq.delete(); out_rdy = 1'b1;
    send_beat(5'd4, 19'd64, 1'b0);
    send_beat(5'd0, 19'd64, 1'b0);
    send_beat(5'd0, 19'd64, 1'b1);
    send_beat(5'd0, 19'd64, 1'b1);
    repeat (5) tick();
    check("sl_nbeats", 32'(outq.size()), 32'd4);
    check_q("sl_a0", 0, {1'b0, 8'd4});
    check_q("sl_a1", 1, {1'b0, 8'd4});
    check_q("sl_a2", 2, {1'b1, 8'd4});
    check_q("sl_b0", 3, {1'b1, 8'd64});

    // Reset mid-frame with saturated beats queued.
    outq.delete(); out_rdy = 1'b0;
    send_beat(5'd0, 19'd300, 1'b0);
    send_beat(5'd0, 19'd300, 1'b0);
    send_beat(5'd0, 19'd300, 1'b0);
    tick();
    check("mr_pre_sat", 32'(sat_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_out_vld", 32'(out_vld), 32'd0);
    check("mr_in_rdy", 32'(in_rdy), 32'd1);
    check("mr_sat_count", 32'(sat_count), 32'd0);
    outq.delete(); fd_cnt = 0; out_rdy = 1'b1;
    send_beat(5'd2, 19'd40, 1'b1);
    repeat (4) tick();
    check("mr_nbeats", 32'(outq.size()), 32'd1);
    check_q("mr_b0", 0, {1'b1, 8'd10});
    check("mr_fd_count", 32'(fd_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
